// File: rtl/clk_div_prog.sv
// Run-time programmable integer clock divider: square-wave clk_out plus a one-cycle
// tick per period, with new divisors taken up only at a period boundary.
module clk_div_prog #(
    parameter int          CNT_W       = 26,
    parameter int unsigned DEFAULT_DIV = 100000
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] cur_div,
    output logic             load_err
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic [CNT_W-1:0] pend_val_q, pend_val_d;
    logic             pend_vld_q, pend_vld_d;
    logic             run_q, run_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             load_err_q, load_err_d;

    logic             ld_ok;
    logic             last;
    logic [CNT_W-1:0] next_div;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] cnt_inc;

    // A load arriving on a boundary edge bypasses the pending register so it
    // governs the very next period.
    always_comb begin
        ld_ok    = div_load && (div_val != '0);
        next_div = ld_ok ? div_val : (pend_vld_q ? pend_val_q : cur_div_q);
        last     = (cnt_q == (cur_div_q - ONE));
        half     = (cur_div_q >> 1) + {{(CNT_W-1){1'b0}}, cur_div_q[0]};
        cnt_inc  = cnt_q + ONE;
    end

    always_comb begin
        cnt_d      = cnt_q;
        cur_div_d  = cur_div_q;
        pend_val_d = pend_val_q;
        pend_vld_d = pend_vld_q;
        run_d      = run_q;
        clk_out_d  = clk_out_q;
        tick_d     = 1'b0;
        load_err_d = div_load && (div_val == '0);

        if (!en) begin
            cnt_d      = '0;
            run_d      = 1'b0;
            clk_out_d  = 1'b0;
            cur_div_d  = next_div;
            pend_vld_d = 1'b0;
        end else if (!run_q || last) begin
            cnt_d      = '0;
            run_d      = 1'b1;
            clk_out_d  = 1'b1;
            tick_d     = 1'b1;
            cur_div_d  = next_div;
            pend_vld_d = 1'b0;
        end else begin
            cnt_d     = cnt_inc;
            clk_out_d = (cnt_inc < half);
            if (ld_ok) begin
                pend_val_d = div_val;
                pend_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            cur_div_q  <= DEF_DIV;
            pend_vld_q <= 1'b0;
            run_q      <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            cur_div_q  <= cur_div_d;
            pend_vld_q <= pend_vld_d;
            run_q      <= run_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            load_err_q <= load_err_d;
        end
    end

    // Pending value is qualified by pend_vld_q, so it needs no reset.
    always_ff @(posedge clk_in) begin
        pend_val_q <= pend_val_d;
    end

    assign clk_out  = clk_out_q;
    assign tick     = tick_q;
    assign cur_div  = cur_div_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: fixed vector table, corner-case sequences and a
// randomized run against a period-queue reference model.
module tb_clk_div_prog;

    localparam int CNT_W = 8;
    localparam int DEF   = 4;

    logic             clk_in = 1'b0;
    logic             rst;
    logic             en;
    logic [CNT_W-1:0] div_val;
    logic             div_load;
    logic             clk_out;
    logic             tick;
    logic [CNT_W-1:0] cur_div;
    logic             load_err;

    clk_div_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .en      (en),
        .div_val (div_val),
        .div_load(div_load),
        .clk_out (clk_out),
        .tick    (tick),
        .cur_div (cur_div),
        .load_err(load_err)
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: each period is expanded into a queue of (clk_out, tick)
    // samples; an empty queue on an enabled edge means a new period starts.
    bit q_clk[$];
    bit q_tick[$];
    int m_div;
    int m_pend;
    bit m_pv;
    bit m_clk, m_tick, m_err;

    task automatic model_reset();
        q_clk.delete();
        q_tick.delete();
        m_div = DEF; m_pv = 0; m_pend = 0;
        m_clk = 0; m_tick = 0; m_err = 0;
    endtask

    task automatic model_edge();
        bit ld;
        int n;
        ld    = div_load && (div_val != 0);
        m_err = div_load && (div_val == 0);
        if (!en) begin
            q_clk.delete();
            q_tick.delete();
            m_clk = 0; m_tick = 0;
            if (ld) m_div = int'(div_val);
            else if (m_pv) m_div = m_pend;
            m_pv = 0;
        end else begin
            if (q_clk.size() == 0) begin
                n = ld ? int'(div_val) : (m_pv ? m_pend : m_div);
                m_div = n;
                m_pv  = 0;
                for (int i = 0; i < n; i++) begin
                    q_clk.push_back(i < (n + 1) / 2);
                    q_tick.push_back(i == 0);
                end
            end else if (ld) begin
                m_pend = int'(div_val);
                m_pv   = 1;
            end
            m_clk  = q_clk.pop_front();
            m_tick = q_tick.pop_front();
        end
    endtask

    task automatic step(input logic e, input logic l, input int v, input string tag);
        en = e; div_load = l; div_val = CNT_W'(v);
        @(posedge clk_in);
        model_edge();
        #1;
        chk({tag, " clk_out"},  int'(clk_out),  int'(m_clk));
        chk({tag, " tick"},     int'(tick),     int'(m_tick));
        chk({tag, " cur_div"},  int'(cur_div),  m_div);
        chk({tag, " load_err"}, int'(load_err), int'(m_err));
    endtask

    typedef struct {
        logic e; logic l; int v;
        logic x_clk; logic x_tick; int x_div; logic x_err;
    } vec_t;

    vec_t vt[19];
    bit   seen;

    initial begin
        //       en ld val  clk tick div err
        vt[0]  = '{1, 0, 0,  1, 1, 4, 0};
        vt[1]  = '{1, 0, 0,  1, 0, 4, 0};
        vt[2]  = '{1, 1, 5,  0, 0, 4, 0};
        vt[3]  = '{1, 0, 0,  0, 0, 4, 0};
        vt[4]  = '{1, 0, 0,  1, 1, 5, 0};
        vt[5]  = '{1, 0, 0,  1, 0, 5, 0};
        vt[6]  = '{1, 0, 0,  1, 0, 5, 0};
        vt[7]  = '{1, 0, 0,  0, 0, 5, 0};
        vt[8]  = '{1, 1, 0,  0, 0, 5, 1};
        vt[9]  = '{1, 0, 0,  1, 1, 5, 0};
        vt[10] = '{0, 0, 0,  0, 0, 5, 0};
        vt[11] = '{0, 0, 0,  0, 0, 5, 0};
        vt[12] = '{0, 0, 0,  0, 0, 5, 0};
        vt[13] = '{1, 0, 0,  1, 1, 5, 0};
        vt[14] = '{1, 0, 0,  1, 0, 5, 0};
        vt[15] = '{1, 0, 0,  1, 0, 5, 0};
        vt[16] = '{1, 0, 0,  0, 0, 5, 0};
        vt[17] = '{1, 0, 0,  0, 0, 5, 0};
        vt[18] = '{1, 0, 0,  1, 1, 5, 0};

        rst = 1'b0; en = 1'b0; div_load = 1'b0; div_val = '0;
        model_reset();
        #12;
        chk("reset clk_out",  int'(clk_out),  0);
        chk("reset tick",     int'(tick),     0);
        chk("reset cur_div",  int'(cur_div),  DEF);
        chk("reset load_err", int'(load_err), 0);
        @(posedge clk_in); #1;
        rst = 1'b1;

        for (int i = 0; i < 19; i++) begin
            step(vt[i].e, vt[i].l, vt[i].v, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl clk_out", i),  int'(clk_out),  int'(vt[i].x_clk));
            chk($sformatf("vec%0d tbl tick", i),     int'(tick),     int'(vt[i].x_tick));
            chk($sformatf("vec%0d tbl cur_div", i),  int'(cur_div),  vt[i].x_div);
            chk($sformatf("vec%0d tbl load_err", i), int'(load_err), int'(vt[i].x_err));
        end

        // N=1: waits for the current 5-cycle period to end.
        step(1, 1, 1, "ld1");
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1, 0, 0, "ld1_wait");
            seen = tick;
        end
        chk("ld1 boundary reached", int'(seen), 1);
        chk("ld1 cur_div", int'(cur_div), 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, "n1");
            chk("n1 clk_out", int'(clk_out), 1);
            chk("n1 tick", int'(tick), 1);
        end

        // N=2 via a load on an N=1 boundary edge.
        step(1, 1, 2, "ld2");
        chk("ld2 cur_div", int'(cur_div), 2);
        chk("ld2 tick", int'(tick), 1);
        step(1, 0, 0, "n2a"); chk("n2a clk_out", int'(clk_out), 0);
        step(1, 0, 0, "n2b"); chk("n2b clk_out", int'(clk_out), 1);
        chk("n2b tick", int'(tick), 1);
        step(1, 0, 0, "n2c"); chk("n2c clk_out", int'(clk_out), 0);

        // Load in the last cycle of a period applies to the very next one.
        step(1, 1, 3, "ldlast");
        chk("ldlast cur_div", int'(cur_div), 3);
        chk("ldlast tick", int'(tick), 1);
        step(1, 0, 0, "n3a"); chk("n3a clk_out", int'(clk_out), 1);
        step(1, 0, 0, "n3b"); chk("n3b clk_out", int'(clk_out), 0);
        step(1, 0, 0, "n3c"); chk("n3c tick", int'(tick), 1);

        // Async reset with a pending load of 7 outstanding.
        step(1, 1, 7, "ld7");
        chk("ld7 clk_out high", int'(clk_out), 1);
        #3 rst = 1'b0;
        #1;
        chk("async rst clk_out", int'(clk_out), 0);
        chk("async rst tick",    int'(tick),    0);
        chk("async rst cur_div", int'(cur_div), DEF);
        model_reset();
        #1 rst = 1'b1;
        step(1, 0, 0, "post_rst0");
        chk("post_rst tick", int'(tick), 1);
        for (int i = 1; i < 4; i++) step(1, 0, 0, "post_rst");
        step(1, 0, 0, "post_rst_bnd");
        chk("post_rst boundary cur_div", int'(cur_div), DEF);
        chk("post_rst boundary tick", int'(tick), 1);

        for (int i = 0; i < 500; i++) begin
            logic e, l;
            int   v;
            e = ($urandom % 8) != 0;
            l = ($urandom % 6) == 0;
            v = (($urandom % 4) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 6));
            step(e, l, v, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
